// File: rtl/hamming_serial_codec.sv
// Serial Hamming codec: loads a frame bit by bit, encodes or decodes it in one
// cycle, then shifts the result out. R parity bits, optional SEC-DED bit c0.
module hamming_serial_codec #(
  parameter int unsigned R   = 4,
  parameter int unsigned EXT = 0
) (
  input  logic clk,
  input  logic RST,
  input  logic shift,
  input  logic mode,
  input  logic sl_inn,
  output logic in_ready,
  output logic sl_out,
  output logic out_valid,
  output logic err_corr,
  output logic err_uncorr
);

  localparam int unsigned N     = (1 << R) - 1;
  localparam int unsigned K     = N - R;
  localparam int unsigned CW    = N + EXT;
  localparam int unsigned CNT_W = R;

  typedef enum logic [1:0] {S_LOAD, S_CALC, S_SHIFT} state_t;

  state_t             r_state, w_state_nx;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_mode;
  logic [N:0]         r_raw;
  logic [N:0]         r_shreg;
  logic               r_sl_out, r_out_valid, r_err_corr, r_err_uncorr;

  logic               w_mode_eff, w_accept, w_last_in, w_last_out;
  logic [CNT_W-1:0]   w_in_last, w_out_last;
  logic [N:0]         w_c, w_res;
  logic [R-1:0]       w_syn;
  logic               w_par, w_corr, w_uncorr;

  function automatic logic f_is_pow2(input int v);
    return (v & (v - 1)) == 0;
  endfunction

  // Mode is taken live on the first bit, from the latch afterwards
  assign w_mode_eff = (r_cnt == '0) ? mode : r_mode;
  assign w_in_last  = w_mode_eff ? CNT_W'(CW - 1) : CNT_W'(K - 1);
  assign w_out_last = r_mode ? CNT_W'(K - 1) : CNT_W'(CW - 1);
  assign w_accept   = (r_state == S_LOAD) && shift;
  assign w_last_in  = w_accept && (r_cnt == w_in_last);
  assign w_last_out = (r_state == S_SHIFT) && shift && (r_cnt == w_out_last);

  assign in_ready   = (r_state == S_LOAD);
  assign sl_out     = r_sl_out;
  assign out_valid  = r_out_valid;
  assign err_corr   = r_err_corr;
  assign err_uncorr = r_err_uncorr;

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) r_state <= S_LOAD;
    else      r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_LOAD:  if (w_last_in) w_state_nx = S_CALC;
      S_CALC:  w_state_nx = S_SHIFT;
      S_SHIFT: if (w_last_out) w_state_nx = S_LOAD;
      default: w_state_nx = S_LOAD;
    endcase
  end

  // Encode/decode of the loaded frame; w_res is the output sequence, bit 0 first
  always_comb begin
    int unsigned v_idx;
    w_c      = '0;
    w_res    = '0;
    w_syn    = '0;
    w_par    = 1'b0;
    w_corr   = 1'b0;
    w_uncorr = 1'b0;
    v_idx    = 0;
    if (!r_mode) begin
      for (int p = 1; p <= int'(N); p++) begin
        if (!f_is_pow2(p)) begin
          w_c[p] = r_raw[v_idx];
          v_idx  = v_idx + 1;
        end
      end
      for (int i = 0; i < int'(R); i++) begin
        for (int p = 1; p <= int'(N); p++) begin
          if (p[i] && !f_is_pow2(p)) w_c[1 << i] = w_c[1 << i] ^ w_c[p];
        end
      end
      for (int p = 1; p <= int'(N); p++) w_res[p-1] = w_c[p];
      if (EXT != 0) w_res[N] = ^w_c[N:1];
    end else begin
      for (int p = 1; p <= int'(N); p++) w_c[p] = r_raw[p-1];
      if (EXT != 0) w_c[0] = r_raw[N];
      for (int p = 1; p <= int'(N); p++) begin
        if (w_c[p]) w_syn = w_syn ^ R'(p);
      end
      w_par = ^w_c;
      if (EXT == 0) begin
        w_corr = (w_syn != '0);
      end else if (w_syn != '0) begin
        w_corr   = w_par;
        w_uncorr = !w_par;
      end else begin
        w_corr = w_par;
      end
      if (w_corr && (w_syn != '0)) w_c[w_syn] = !w_c[w_syn];
      for (int p = 1; p <= int'(N); p++) begin
        if (!f_is_pow2(p)) begin
          w_res[v_idx] = w_c[p];
          v_idx        = v_idx + 1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_cnt        <= '0;
      r_mode       <= 1'b0;
      r_raw        <= '0;
      r_shreg      <= '0;
      r_sl_out     <= 1'b0;
      r_out_valid  <= 1'b0;
      r_err_corr   <= 1'b0;
      r_err_uncorr <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_accept) begin
            r_raw[r_cnt] <= sl_inn;
            if (r_cnt == '0) r_mode <= mode;
            r_cnt <= w_last_in ? '0 : r_cnt + CNT_W'(1);
          end
        end
        S_CALC: begin
          r_sl_out     <= w_res[0];
          r_shreg      <= {1'b0, w_res[N:1]};
          r_out_valid  <= 1'b1;
          r_err_corr   <= w_corr;
          r_err_uncorr <= w_uncorr;
          r_cnt        <= '0;
        end
        S_SHIFT: begin
          if (shift) begin
            r_shreg  <= {1'b0, r_shreg[N:1]};
            r_sl_out <= w_last_out ? 1'b0 : r_shreg[0];
            r_cnt    <= w_last_out ? '0 : r_cnt + CNT_W'(1);
            if (w_last_out) r_out_valid <= 1'b0;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_serial_codec.sv
// Scoreboard bench for hamming_serial_codec: u0 is (15,11), u1 is SEC-DED (16,11).
module tb_hamming_serial_codec;

  typedef struct packed { logic b; logic ec; logic eu; } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] shift_v, mode_v, sin_v;
  logic [1:0] rdy_v, sl_v, val_v, ec_v, eu_v;
  int n_checks = 0;
  int n_errors = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  hamming_serial_codec #(.R(4), .EXT(0)) u0 (
    .clk(clk), .RST(rst_n), .shift(shift_v[0]), .mode(mode_v[0]), .sl_inn(sin_v[0]),
    .in_ready(rdy_v[0]), .sl_out(sl_v[0]), .out_valid(val_v[0]),
    .err_corr(ec_v[0]), .err_uncorr(eu_v[0]));

  hamming_serial_codec #(.R(4), .EXT(1)) u1 (
    .clk(clk), .RST(rst_n), .shift(shift_v[1]), .mode(mode_v[1]), .sl_inn(sin_v[1]),
    .in_ready(rdy_v[1]), .sl_out(sl_v[1]), .out_valid(val_v[1]),
    .err_corr(ec_v[1]), .err_uncorr(eu_v[1]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic push(input int d, input logic [15:0] v, input int len,
                      input logic ec, input logic eu);
    for (int i = 0; i < len; i++) begin
      exp_t e;
      e.b = v[i]; e.ec = ec; e.eu = eu;
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  // Pop one expected bit whenever the DUT hands over a bit
  task automatic mon(input int d);
    exp_t e;
    if (val_v[d] && shift_v[d]) begin
      check($sformatf("expected_bit_pending_d%0d", d), 32'(qsize(d) != 0), 1);
      if (qsize(d) != 0) begin
        if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
        check($sformatf("sl_out_d%0d", d), 32'(sl_v[d]), 32'(e.b));
        check($sformatf("err_corr_d%0d", d), 32'(ec_v[d]), 32'(e.ec));
        check($sformatf("err_uncorr_d%0d", d), 32'(eu_v[d]), 32'(e.eu));
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0);
      mon(1);
    end
  end

  // Sends bits v[0..len-1]; mode is driven inverted after the first bit
  task automatic send(input int d, input logic [15:0] v, input int len, input logic m);
    for (int c = 0; c < 50 && !rdy_v[d]; c++) begin @(posedge clk); #1; end
    check($sformatf("in_ready_before_frame_d%0d", d), 32'(rdy_v[d]), 1);
    for (int i = 0; i < len; i++) begin
      sin_v[d]   = v[i];
      mode_v[d]  = (i == 0) ? m : ~m;
      shift_v[d] = 1'b1;
      @(posedge clk); #1;
    end
    sin_v[d] = 1'b0;
  endtask

  task automatic wait_valid(input int d);
    for (int c = 0; c < 20 && !val_v[d]; c++) begin @(posedge clk); #1; end
    check($sformatf("out_valid_rise_d%0d", d), 32'(val_v[d]), 1);
  endtask

  task automatic drain(input int d);
    shift_v[d] = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (!val_v[d] && qsize(d) == 0) break;
      @(posedge clk); #1;
    end
    shift_v[d] = 1'b0;
    check($sformatf("frame_drained_d%0d", d), 32'(val_v[d] || qsize(d) != 0), 0);
  endtask

  task automatic frame(input int d, input logic [15:0] din, input int ilen, input logic m,
                       input logic [15:0] dout, input int olen, input logic ec, input logic eu);
    push(d, dout, olen, ec, eu);
    send(d, din, ilen, m);
    drain(d);
  endtask

  initial begin
    logic held;
    rst_n = 1'b0; shift_v = '0; mode_v = '0; sin_v = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_in_ready_d%0d", d), 32'(rdy_v[d]), 1);
      check($sformatf("rst_out_valid_d%0d", d), 32'(val_v[d]), 0);
      check($sformatf("rst_sl_out_d%0d", d), 32'(sl_v[d]), 0);
      check($sformatf("rst_err_d%0d", d), 32'({ec_v[d], eu_v[d]}), 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Encode 11 ones, with an explicit CALC-cycle latency check
    push(0, 16'h7FFF, 15, 1'b0, 1'b0);
    send(0, 16'h07FF, 11, 1'b0);
    check("calc_out_valid_low", 32'(val_v[0]), 0);
    check("calc_in_ready_low", 32'(rdy_v[0]), 0);
    @(posedge clk); #1;
    check("first_bit_latency", 32'(val_v[0]), 1);
    drain(0);

    frame(0, 16'h0001, 11, 1'b0, 16'h0007, 15, 1'b0, 1'b0);
    frame(0, 16'h7FDF, 15, 1'b1, 16'h07FF, 11, 1'b1, 1'b0);
    check("err_corr_held_after_frame", 32'(ec_v[0]), 1);

    // Backpressure: stall 5 cycles with c4 (a 1) on the line
    push(0, 16'h408B, 15, 1'b0, 1'b0);
    send(0, 16'h0400, 11, 1'b0);
    wait_valid(0);
    repeat (3) begin @(posedge clk); #1; end
    shift_v[0] = 1'b0;
    held = sl_v[0];
    check("stall_bit_value", 32'(held), 1);
    repeat (5) begin
      @(posedge clk); #1;
      check("stall_sl_out", 32'(sl_v[0]), 32'(held));
      check("stall_out_valid", 32'(val_v[0]), 1);
    end
    drain(0);

    // Reset while bit 7 of an encode frame is on the line
    push(0, 16'h7FFF, 15, 1'b0, 1'b0);
    send(0, 16'h07FF, 11, 1'b0);
    wait_valid(0);
    repeat (7) begin @(posedge clk); #1; end
    check("pre_reset_out_valid", 32'(val_v[0]), 1);
    #2;
    rst_n = 1'b0;
    shift_v[0] = 1'b0;
    #1;
    q0.delete();
    check("reset_out_valid", 32'(val_v[0]), 0);
    check("reset_sl_out", 32'(sl_v[0]), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("post_reset_in_ready", 32'(rdy_v[0]), 1);
    frame(0, 16'h0001, 11, 1'b0, 16'h0007, 15, 1'b0, 1'b0);

    // SEC-DED instance
    frame(1, 16'h0001, 11, 1'b0, 16'h8007, 16, 1'b0, 1'b0);
    frame(1, 16'h8004, 16, 1'b1, 16'h0001, 11, 1'b0, 1'b1);
    frame(1, 16'h8017, 16, 1'b1, 16'h0001, 11, 1'b1, 1'b0);
    frame(1, 16'h0007, 16, 1'b1, 16'h0001, 11, 1'b1, 1'b0);
    frame(1, 16'h8007, 16, 1'b1, 16'h0001, 11, 1'b0, 1'b0);
    frame(1, 16'h0001, 11, 1'b0, 16'h8007, 16, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hamming_serial_codec.md
Name: hamming_serial_codec

Overview:
- Parametrised serial Hamming codec. One instance runs either encode or decode per frame, selected by a mode input.
- Generalises the fixed (15,11) serial encoder/decoder to any code with R parity bits: K=2^R-1-R data bits, N=2^R-1 code bits.
- Optional extended overall-parity bit gives SEC-DED.
- Sits between the serial line interface and the data path. It is half-duplex: load a frame, compute, shift out the result, repeat.

Parameters:
- R, 4, number of Hamming parity bits; legal range 3..6. Default gives (15,11).
- EXT, 0, 1 appends overall parity bit c0, so the code is SEC-DED with length N+1.

Ports:
- clk  input  1  system clock, rising edge.
- RST  input  1  asynchronous active-low reset.
- shift  input  1  bit-advance enable, shared by input and output sides.
- mode  input  1  0 = encode, 1 = decode. Latched at frame start.
- sl_inn  input  1  serial data in.
- in_ready  output  1  block accepts sl_inn this cycle.
- sl_out  output  1  serial data out.
- out_valid  output  1  sl_out carries a valid result bit.
- err_corr  output  1  decode: single error detected and corrected.
- err_uncorr  output  1  decode: double error detected (EXT=1 only).

Behaviour:
- Lengths:
  - IN_LEN = K when encoding, N+EXT when decoding.
  - OUT_LEN = N+EXT when encoding, K when decoding.
- Codeword layout:
  - Positions c[1..N]. Parity bit p_i sits at position 2^i and is even parity over all positions with address bit i set.
  - Data bits fill the non-power-of-2 positions in ascending order: first data bit received goes to c[3].
  - Transmit order is c[1] first through c[N], then c[0] if EXT=1. c[0] is even parity over c[1..N] plus itself.
  - Decoded data is output in the same order it was originally received.
- States:
  - LOAD:
    - in_ready=1.
    - A bit is accepted on an edge with shift=1. The bit counter increments.
    - mode is latched on the first accepted bit, when count=0.
    - After accepting bit IN_LEN, the counter clears and the next state is CALC.
  - CALC: one cycle. in_ready=0, out_valid=0. Encode or decode is computed and captured at the end of the cycle.
  - SHIFT_OUT:
    - out_valid=1 and sl_out = current output bit.
    - Advances on an edge with shift=1.
    - After OUT_LEN bits have been consumed, the next state is LOAD with out_valid=0.
    - While shift=0, sl_out and state hold.
- Latency: last input bit accepted at edge E -> CALC during cycle E..E+1 -> first output bit valid after edge E+1.
- All outputs are registered except in_ready, which is decoded from state.
- Decode rules (s = syndrome, XOR of the addresses of all set bits in c[1..N]; P = overall parity):
  - EXT=0:
    - s≠0: flip c[s], err_corr=1.
    - s=0: no error.
  - EXT=1:
    - s≠0 and P odd: flip c[s], err_corr=1.
    - s≠0 and P even: err_uncorr=1, data is output uncorrected.
    - s=0 and P odd: error in c[0], err_corr=1, data unchanged.
    - s=0 and P even: no error.
- err_corr and err_uncorr:
  - Updated at the end of each CALC and held until the next CALC.
  - Forced to 0 by an encode frame.
- Reset (async, any time, including mid-frame):
  - State returns to LOAD and counters clear.
  - sl_out=0, out_valid=0, err_corr=0, err_uncorr=0, in_ready=1 after release.
  - A partial frame is discarded.
- mode changes mid-frame are ignored until the next frame start.

Test Plan:
- R=4, EXT=0, encode, 11 ones -> after CALC, 15 ones on sl_out with out_valid high for 15 shift cycles, both error flags 0.
- R=4, EXT=0, encode, data 1 followed by ten 0s -> sl_out sequence 1,1,1 then twelve 0s.
- R=4, EXT=0, decode, all-ones codeword with c[6] flipped -> 11 ones out, err_corr=1, err_uncorr=0.
- R=4, EXT=1, decode, codeword 1,1,1,0×12,1 with c[1] and c[2] flipped -> err_uncorr=1, err_corr=0, data output uncorrected (1 then ten 0s).
- Backpressure: hold shift=0 for 5 cycles mid-output -> sl_out, out_valid and bit index frozen; the sequence resumes intact when shift returns to 1.
- Assert RST low during SHIFT_OUT bit 7 -> out_valid=0 and sl_out=0 immediately. After release, in_ready=1 and a fresh 11-bit encode frame produces correct output.
